// File: rtl/fp_addsub_arbiter_pkg.sv
// Shared types and encodings for the add/sub arbiter: controller states and
// operation codes driven onto the unit's addsub input.
package fp_addsub_arbiter_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fp_addsub_arbiter_rr.sv
// Combinational round-robin grant: first asserted request at or above the
// pointer, wrapping modulo N_REQ.
module fp_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id
);

    logic [ID_W:0] idx;

    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(N_REQ)) begin
                idx = idx - (ID_W + 1)'(N_REQ);
            end
            if (req[idx[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one FP add/sub unit among N_REQ requesters: round-robin accept, one-cycle
// control strobe, result returned with requester id over a valid/ready channel.
module fp_addsub_arbiter
    import fp_addsub_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]      req_sub,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [FP_W-1:0]       resp_data,
    output logic                  resp_exception,
    output logic [ID_W-1:0]       resp_id,
    output logic                  busy,
    output logic [FP_W-1:0]       alu_a,
    output logic [FP_W-1:0]       alu_b,
    output logic                  alu_addsub,
    output logic                  alu_control,
    input  logic [FP_W-1:0]       alu_out,
    input  logic                  alu_exception
);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] ptr;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic [FP_W-1:0] win_a;
    logic [FP_W-1:0] win_b;
    logic            win_sub;
    logic            accept;

    fp_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign win_a   = req_a[32*grant_id +: 32];
    assign win_b   = req_b[32*grant_id +: 32];
    assign win_sub = req_sub[grant_id];
    assign accept  = (state == S_IDLE) && grant_valid;
    assign busy    = (state != S_IDLE);

    always_comb begin
        req_ready = '0;
        if (accept && !reset) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (grant_valid) state_next = S_STROBE;
            S_STROBE: state_next = S_RESP;
            S_RESP:   if (resp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Operand/response registers; resp_valid only drops on the handshake edge,
    // so a new acceptance can never coincide with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr            <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_addsub     <= 1'b0;
            alu_control    <= 1'b0;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            resp_exception <= 1'b0;
            resp_id        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        alu_a       <= win_a;
                        alu_b       <= win_b;
                        alu_addsub  <= win_sub ? OP_SUB : OP_ADD;
                        alu_control <= 1'b1;
                        resp_id     <= grant_id;
                        ptr         <= (grant_id == ID_W'(N_REQ - 1)) ? '0
                                                                     : grant_id + ID_W'(1);
                    end
                end
                S_STROBE: begin
                    resp_data      <= alu_out;
                    resp_exception <= alu_exception;
                    resp_valid     <= 1'b1;
                    alu_control    <= 1'b0;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    alu_control <= 1'b0;
                end
            endcase
        end
    end

endmodule
